// File: rtl/gb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// gb_mem_arbiter
//
// Shares one single-port synchronous block RAM between the gameboy main bus
// (WRAM at C000-DFFF plus its echo at E000-FDFF) and the VRAM bus
// (8000-9FFF). RAM address bit ADDR_W-1 selects the region (1 = VRAM,
// 0 = WRAM). New accesses on either bus are latched into a per-port pending
// slot. A small IDLE -> GRANT -> WAIT FSM then services them one at a time.
// Read data is held on Di / Di_vram until that port's next read completes.
//
// Build option:
//   MEM_ARB_VRAM_PRIORITY_EN  defined   -> VRAM always wins a tie
//                             undefined -> round-robin on last_grant
//
// Ports:
//   core_clock, reset        clock and synchronous active-high reset
//   A, Do, wr_n, rd_n, cs_n  main bus address, write data and strobes
//   Di                       main bus read data
//   A_vram, Do_vram,
//   wr_vram_n, rd_vram_n,
//   cs_vram_n                VRAM bus address, write data and strobes
//   Di_vram                  VRAM bus read data
//   mem_addr, mem_wdata,
//   mem_en, mem_we           RAM command outputs
//   mem_rdata                RAM read data, RD_LAT cycles after mem_en
//   dbg_conflict             one-cycle pulse when both ports tie at arbitration
// ---------------------------------------------------------------------------
module gb_mem_arbiter #(
    parameter int          RD_LAT   = 1,
    parameter int          ADDR_W   = 14,
    parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
    input  logic              core_clock,
    input  logic              reset,
    input  logic [15:0]       A,
    input  logic [7:0]        Do,
    input  logic              wr_n,
    input  logic              rd_n,
    input  logic              cs_n,
    output logic [7:0]        Di,
    input  logic [15:0]       A_vram,
    input  logic [7:0]        Do_vram,
    input  logic              wr_vram_n,
    input  logic              rd_vram_n,
    input  logic              cs_vram_n,
    output logic [7:0]        Di_vram,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_en,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              dbg_conflict
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_WAIT
    } state_t;

    localparam logic PORT_MAIN = 1'b0;
    localparam logic PORT_VRAM = 1'b1;

    state_t            state_q, state_d;
    logic              win_q, win_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        wait_cnt_q, wait_cnt_d;

    logic              main_act_q, main_act_d;
    logic [15:0]       main_a_q, main_a_d;
    logic              main_pend_q, main_pend_d;
    logic [ADDR_W-1:0] main_addr_q, main_addr_d;
    logic [7:0]        main_data_q, main_data_d;
    logic              main_wr_q, main_wr_d;

    logic              vram_act_q, vram_act_d;
    logic [15:0]       vram_a_q, vram_a_d;
    logic              vram_pend_q, vram_pend_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic [7:0]        vram_data_q, vram_data_d;
    logic              vram_wr_q, vram_wr_d;

    logic [7:0]        di_q, di_d;
    logic [7:0]        di_vram_q, di_vram_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              dbg_q, dbg_d;

    logic              main_active, main_new, main_mapped;
    logic              vram_active, vram_new, vram_mapped;
    logic [ADDR_W-1:0] main_map_addr, vram_map_addr;
    logic              any_pend, both_pend, pick_vram, taking_grant;
    logic              read_done;

    // Request detection: a port is active while selected with either strobe
    // low; a fresh request is a rising active edge or an address change while
    // the port stays active. Echo RAM excludes FE00-FFFF (OAM/IO/HRAM).
    always_comb begin
        main_active = ~cs_n & (~rd_n | ~wr_n);
        vram_active = ~cs_vram_n & (~rd_vram_n | ~wr_vram_n);
        main_new    = main_active & (~main_act_q | (A != main_a_q));
        vram_new    = vram_active & (~vram_act_q | (A_vram != vram_a_q));
        main_mapped = (A[15:13] == 3'b110) |
                      ((A[15:13] == 3'b111) & (A[12:9] != 4'hF));
        vram_mapped = (A_vram[15:13] == 3'b100);

        main_map_addr           = '0;
        main_map_addr[12:0]     = A[12:0];
        main_map_addr[ADDR_W-1] = 1'b0;
        vram_map_addr           = '0;
        vram_map_addr[12:0]     = A_vram[12:0];
        vram_map_addr[ADDR_W-1] = 1'b1;
    end

    // Arbitration: a lone pending port wins outright; on a tie the winner is
    // either fixed (VRAM) or the port that was not granted last time.
    always_comb begin
        any_pend  = main_pend_q | vram_pend_q;
        both_pend = main_pend_q & vram_pend_q;
`ifdef MEM_ARB_VRAM_PRIORITY_EN
        pick_vram = vram_pend_q;
`else
        pick_vram = both_pend ? ~last_grant_q : vram_pend_q;
`endif
        taking_grant = (state_q == ST_IDLE) & any_pend;
        read_done    = (state_q == ST_WAIT) & (wait_cnt_q == 2'd0);
    end

    // Pending slots. The winner's slot is released on the same edge its
    // contents are copied into the RAM command registers, so a request that
    // arrives on that edge (or any later one) re-arms the slot and is kept.
    always_comb begin
        main_act_d  = main_active;
        main_a_d    = A;
        main_pend_d = main_pend_q;
        main_addr_d = main_addr_q;
        main_data_d = main_data_q;
        main_wr_d   = main_wr_q;
        vram_act_d  = vram_active;
        vram_a_d    = A_vram;
        vram_pend_d = vram_pend_q;
        vram_addr_d = vram_addr_q;
        vram_data_d = vram_data_q;
        vram_wr_d   = vram_wr_q;

        if (taking_grant && !pick_vram) begin
            main_pend_d = 1'b0;
        end
        if (taking_grant && pick_vram) begin
            vram_pend_d = 1'b0;
        end
        if (main_new && main_mapped) begin
            main_pend_d = 1'b1;
            main_addr_d = main_map_addr;
            main_data_d = Do;
            main_wr_d   = ~wr_n;
        end
        if (vram_new && vram_mapped) begin
            vram_pend_d = 1'b1;
            vram_addr_d = vram_map_addr;
            vram_data_d = Do_vram;
            vram_wr_d   = ~wr_vram_n;
        end
    end

    // Read data holding registers: updated only by a completed read for the
    // same port, or forced to open bus by an unmapped read on that port.
    always_comb begin
        di_d      = di_q;
        di_vram_d = di_vram_q;
        if (read_done && win_q == PORT_MAIN) begin
            di_d = mem_rdata;
        end
        if (read_done && win_q == PORT_VRAM) begin
            di_vram_d = mem_rdata;
        end
        if (main_new && !main_mapped && wr_n) begin
            di_d = OPEN_BUS;
        end
        if (vram_new && !vram_mapped && wr_vram_n) begin
            di_vram_d = OPEN_BUS;
        end
    end

    // Service FSM. RAM command outputs are registered and are high exactly
    // during the GRANT cycle.
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        dbg_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_pend) begin
                    state_d      = ST_GRANT;
                    win_d        = pick_vram;
                    last_grant_d = pick_vram;
                    mem_en_d     = 1'b1;
                    mem_we_d     = pick_vram ? vram_wr_q : main_wr_q;
                    mem_addr_d   = pick_vram ? vram_addr_q : main_addr_q;
                    mem_wdata_d  = pick_vram ? vram_data_q : main_data_q;
                    dbg_d        = both_pend;
                end
            end
            ST_GRANT: begin
                wait_cnt_d = 2'(RD_LAT - 1);
                state_d    = mem_we_q ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any cycle in flight and lets the main bus
    // win the first tie.
    always_ff @(posedge core_clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            win_q        <= PORT_MAIN;
            last_grant_q <= PORT_VRAM;
            wait_cnt_q   <= 2'd0;
            main_act_q   <= 1'b0;
            main_a_q     <= 16'h0000;
            main_pend_q  <= 1'b0;
            main_addr_q  <= '0;
            main_data_q  <= 8'h00;
            main_wr_q    <= 1'b0;
            vram_act_q   <= 1'b0;
            vram_a_q     <= 16'h0000;
            vram_pend_q  <= 1'b0;
            vram_addr_q  <= '0;
            vram_data_q  <= 8'h00;
            vram_wr_q    <= 1'b0;
            di_q         <= OPEN_BUS;
            di_vram_q    <= OPEN_BUS;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'h00;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            dbg_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            main_act_q   <= main_act_d;
            main_a_q     <= main_a_d;
            main_pend_q  <= main_pend_d;
            main_addr_q  <= main_addr_d;
            main_data_q  <= main_data_d;
            main_wr_q    <= main_wr_d;
            vram_act_q   <= vram_act_d;
            vram_a_q     <= vram_a_d;
            vram_pend_q  <= vram_pend_d;
            vram_addr_q  <= vram_addr_d;
            vram_data_q  <= vram_data_d;
            vram_wr_q    <= vram_wr_d;
            di_q         <= di_d;
            di_vram_q    <= di_vram_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            dbg_q        <= dbg_d;
        end
    end

    assign Di           = di_q;
    assign Di_vram      = di_vram_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign dbg_conflict = dbg_q;

endmodule

// File: tb/tb_gb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gb_mem_arbiter
//
// Directed bench for gb_mem_arbiter with RD_LAT = 1. A behavioural 16 KB
// single-port RAM with one cycle of read latency sits on the RAM side; the
// bench can also preload it through a private port so that arbitration
// history is not disturbed.
// ---------------------------------------------------------------------------
module tb_gb_mem_arbiter;

    logic        core_clock = 1'b0;
    logic        reset;
    logic [15:0] A;
    logic [7:0]  Do;
    logic        wr_n, rd_n, cs_n;
    logic [7:0]  Di;
    logic [15:0] A_vram;
    logic [7:0]  Do_vram;
    logic        wr_vram_n, rd_vram_n, cs_vram_n;
    logic [7:0]  Di_vram;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_rdata;
    logic        dbg_conflict;

    logic [7:0]  ram [0:16383];
    logic [7:0]  rdata_q;
    logic        pre_en;
    logic [13:0] pre_addr;
    logic [7:0]  pre_data;

    int checks = 0;
    int passes = 0;

    gb_mem_arbiter #(.RD_LAT(1), .ADDR_W(14), .OPEN_BUS(8'hFF)) dut (
        .core_clock   (core_clock),
        .reset        (reset),
        .A            (A),
        .Do           (Do),
        .wr_n         (wr_n),
        .rd_n         (rd_n),
        .cs_n         (cs_n),
        .Di           (Di),
        .A_vram       (A_vram),
        .Do_vram      (Do_vram),
        .wr_vram_n    (wr_vram_n),
        .rd_vram_n    (rd_vram_n),
        .cs_vram_n    (cs_vram_n),
        .Di_vram      (Di_vram),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .dbg_conflict (dbg_conflict)
    );

    always #15 core_clock = ~core_clock;

    // Behavioural RAM: one-cycle read latency, plus a bench-only preload port.
    always @(posedge core_clock) begin
        if (pre_en) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
            end else begin
                rdata_q <= ram[mem_addr];
            end
        end
    end
    assign mem_rdata = rdata_q;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge core_clock);
        #1;
    endtask

    task automatic preload(input logic [13:0] addr, input logic [7:0] data);
        pre_en   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic main_drive(input logic [15:0] addr, input logic [7:0] data,
                              input logic is_write);
        A    = addr;
        Do   = data;
        cs_n = 1'b0;
        wr_n = ~is_write;
        rd_n = is_write;
    endtask

    task automatic main_release();
        cs_n = 1'b1;
        wr_n = 1'b1;
        rd_n = 1'b1;
    endtask

    task automatic vram_drive(input logic [15:0] addr, input logic [7:0] data,
                              input logic is_write);
        A_vram    = addr;
        Do_vram   = data;
        cs_vram_n = 1'b0;
        wr_vram_n = ~is_write;
        rd_vram_n = is_write;
    endtask

    task automatic vram_release();
        cs_vram_n = 1'b1;
        wr_vram_n = 1'b1;
        rd_vram_n = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (Di !== 8'hFF) $display("[TB] FAIL rst_di: got %h expected %h", Di, 8'hFF); else passes++;
        checks++; if (Di_vram !== 8'hFF) $display("[TB] FAIL rst_di_vram: got %h expected %h", Di_vram, 8'hFF); else passes++;
        checks++; if (mem_en !== 1'b0) $display("[TB] FAIL rst_mem_en: got %b expected 0", mem_en); else passes++;
        checks++; if (mem_we !== 1'b0) $display("[TB] FAIL rst_mem_we: got %b expected 0", mem_we); else passes++;
        checks++; if (mem_addr !== 14'h0000) $display("[TB] FAIL rst_mem_addr: got %h expected 0000", mem_addr); else passes++;
        checks++; if (mem_wdata !== 8'h00) $display("[TB] FAIL rst_mem_wdata: got %h expected 00", mem_wdata); else passes++;
        checks++; if (dbg_conflict !== 1'b0) $display("[TB] FAIL rst_dbg: got %b expected 0", dbg_conflict); else passes++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_main_write_read();
        main_drive(16'hC123, 8'h5A, 1'b1);
        tick();
        main_release();
        tick();
        checks++; if (mem_en !== 1'b1) $display("[TB] FAIL wr_grant_en: got %b expected 1", mem_en); else passes++;
        checks++; if (mem_we !== 1'b1) $display("[TB] FAIL wr_grant_we: got %b expected 1", mem_we); else passes++;
        checks++; if (mem_addr !== 14'h0123) $display("[TB] FAIL wr_grant_addr: got %h expected 0123", mem_addr); else passes++;
        checks++; if (mem_wdata !== 8'h5A) $display("[TB] FAIL wr_grant_wdata: got %h expected 5a", mem_wdata); else passes++;
        tick();
        checks++; if (mem_en !== 1'b0) $display("[TB] FAIL wr_one_cycle: got %b expected 0", mem_en); else passes++;

        main_drive(16'hC123, 8'h00, 1'b0);
        tick();
        main_release();
        tick();
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) $display("[TB] FAIL rd_grant: got en=%b we=%b expected en=1 we=0", mem_en, mem_we); else passes++;
        checks++; if (mem_addr !== 14'h0123) $display("[TB] FAIL rd_grant_addr: got %h expected 0123", mem_addr); else passes++;
        tick();
        checks++; if (Di !== 8'hFF) $display("[TB] FAIL rd_di_early: got %h expected ff", Di); else passes++;
        tick();
        checks++; if (Di !== 8'h5A) $display("[TB] FAIL rd_di_c123: got %h expected 5a", Di); else passes++;
        tick();
    endtask

    task automatic test_echo();
        main_drive(16'hE010, 8'h3C, 1'b1);
        tick();
        main_release();
        tick();
        checks++; if (mem_addr !== 14'h0010 || mem_we !== 1'b1) $display("[TB] FAIL echo_wr: got addr=%h we=%b expected addr=0010 we=1", mem_addr, mem_we); else passes++;
        tick();
        main_drive(16'hC010, 8'h00, 1'b0);
        tick();
        main_release();
        tick();
        checks++; if (mem_addr !== 14'h0010 || mem_en !== 1'b1) $display("[TB] FAIL echo_rd: got addr=%h en=%b expected addr=0010 en=1", mem_addr, mem_en); else passes++;
        tick();
        tick();
        checks++; if (Di !== 8'h3C) $display("[TB] FAIL echo_di: got %h expected 3c", Di); else passes++;
        tick();
    endtask

    task automatic test_unmapped();
        int en_seen;
        main_drive(16'hFF80, 8'h00, 1'b0);
        tick();
        checks++; if (Di !== 8'hFF) $display("[TB] FAIL unmap_rd_di: got %h expected ff", Di); else passes++;
        main_release();
        en_seen = (mem_en === 1'b1) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_en === 1'b1) en_seen++;
        end
        checks++; if (en_seen != 0) $display("[TB] FAIL unmap_rd_en: got %0d enables expected 0", en_seen); else passes++;

        main_drive(16'h4000, 8'hAA, 1'b1);
        en_seen = 0;
        tick();
        main_release();
        for (int i = 0; i < 4; i++) begin
            if (mem_en === 1'b1) en_seen++;
            tick();
        end
        checks++; if (en_seen != 0) $display("[TB] FAIL unmap_wr_en: got %0d enables expected 0", en_seen); else passes++;
    endtask

    task automatic test_tie();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        preload(14'h0200, 8'h11);
        preload(14'h2005, 8'h22);
        preload(14'h0201, 8'h33);
        tick();

        main_drive(16'hC200, 8'h00, 1'b0);
        vram_drive(16'h8005, 8'h00, 1'b0);
        tick();
        main_release();
        vram_release();
        tick();
`ifdef MEM_ARB_VRAM_PRIORITY_EN
        checks++; if (mem_addr !== 14'h2005 || dbg_conflict !== 1'b1) $display("[TB] FAIL tie1_grant: got addr=%h dbg=%b expected addr=2005 dbg=1", mem_addr, dbg_conflict); else passes++;
        main_drive(16'hC201, 8'h00, 1'b0);
        tick();
        main_release();
        checks++; if (dbg_conflict !== 1'b0) $display("[TB] FAIL tie1_dbg_pulse: got %b expected 0", dbg_conflict); else passes++;
        tick();
        checks++; if (Di_vram !== 8'h22) $display("[TB] FAIL tie1_di_vram: got %h expected 22", Di_vram); else passes++;
        tick();
        checks++; if (mem_addr !== 14'h0201 || dbg_conflict !== 1'b0) $display("[TB] FAIL tie2_grant: got addr=%h dbg=%b expected addr=0201 dbg=0", mem_addr, dbg_conflict); else passes++;
        tick();
        tick();
        checks++; if (Di !== 8'h33) $display("[TB] FAIL tie2_di: got %h expected 33", Di); else passes++;
`else
        checks++; if (mem_addr !== 14'h0200 || dbg_conflict !== 1'b1) $display("[TB] FAIL tie1_grant: got addr=%h dbg=%b expected addr=0200 dbg=1", mem_addr, dbg_conflict); else passes++;
        main_drive(16'hC201, 8'h00, 1'b0);
        tick();
        main_release();
        checks++; if (dbg_conflict !== 1'b0) $display("[TB] FAIL tie1_dbg_pulse: got %b expected 0", dbg_conflict); else passes++;
        tick();
        checks++; if (Di !== 8'h11) $display("[TB] FAIL tie1_di: got %h expected 11", Di); else passes++;
        tick();
        checks++; if (mem_addr !== 14'h2005 || dbg_conflict !== 1'b1) $display("[TB] FAIL tie2_grant: got addr=%h dbg=%b expected addr=2005 dbg=1", mem_addr, dbg_conflict); else passes++;
        tick();
        tick();
        checks++; if (Di_vram !== 8'h22) $display("[TB] FAIL tie2_di_vram: got %h expected 22", Di_vram); else passes++;
        tick();
        checks++; if (mem_addr !== 14'h0201 || dbg_conflict !== 1'b0) $display("[TB] FAIL tie3_grant: got addr=%h dbg=%b expected addr=0201 dbg=0", mem_addr, dbg_conflict); else passes++;
        tick();
        tick();
        checks++; if (Di !== 8'h33) $display("[TB] FAIL tie3_di: got %h expected 33", Di); else passes++;
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        preload(14'h2000, 8'hA1);
        preload(14'h2001, 8'hB2);
        tick();
        vram_drive(16'h8000, 8'h00, 1'b0);
        tick();
        tick();
        checks++; if (mem_en !== 1'b1 || mem_addr !== 14'h2000) $display("[TB] FAIL b2b_grant0: got en=%b addr=%h expected en=1 addr=2000", mem_en, mem_addr); else passes++;
        A_vram = 16'h8001;
        tick();
        tick();
        checks++; if (Di_vram !== 8'hA1) $display("[TB] FAIL b2b_di0: got %h expected a1", Di_vram); else passes++;
        tick();
        checks++; if (mem_en !== 1'b1 || mem_addr !== 14'h2001) $display("[TB] FAIL b2b_grant1: got en=%b addr=%h expected en=1 addr=2001", mem_en, mem_addr); else passes++;
        tick();
        checks++; if (Di_vram !== 8'hA1) $display("[TB] FAIL b2b_hold: got %h expected a1", Di_vram); else passes++;
        tick();
        checks++; if (Di_vram !== 8'hB2) $display("[TB] FAIL b2b_di1: got %h expected b2", Di_vram); else passes++;
        vram_release();
        tick();
    endtask

    task automatic test_reset_mid_read();
        int cmd_seen;
        main_drive(16'hC123, 8'h00, 1'b0);
        tick();
        main_release();
        tick();
        checks++; if (mem_en !== 1'b1) $display("[TB] FAIL rmid_grant: got %b expected 1", mem_en); else passes++;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) $display("[TB] FAIL rmid_en: got en=%b we=%b expected en=0 we=0", mem_en, mem_we); else passes++;
        checks++; if (Di !== 8'hFF) $display("[TB] FAIL rmid_di: got %h expected ff", Di); else passes++;
        reset = 1'b0;
        cmd_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_en === 1'b1 || mem_we === 1'b1) cmd_seen++;
        end
        checks++; if (cmd_seen != 0) $display("[TB] FAIL rmid_spurious: got %0d commands expected 0", cmd_seen); else passes++;
        checks++; if (Di !== 8'hFF) $display("[TB] FAIL rmid_di_hold: got %h expected ff", Di); else passes++;
    endtask

    initial begin
        reset     = 1'b1;
        pre_en    = 1'b0;
        pre_addr  = 14'h0000;
        pre_data  = 8'h00;
        A         = 16'h0000;
        Do        = 8'h00;
        A_vram    = 16'h0000;
        Do_vram   = 8'h00;
        main_release();
        vram_release();
        tick();

        test_reset();
        test_main_write_read();
        test_echo();
        test_unmapped();
        test_tie();
        test_back_to_back();
        test_reset_mid_read();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
